// File: rtl/wb_trace_fifo.sv
// Commit-trace FIFO: captures each retired instruction from the debug_wb_* port and replays it
// over a show-ahead valid/ready port, with retire/drop counters and a sticky overflow flag.
module wb_trace_fifo #(
  parameter int DEPTH   = 16,
  parameter bit DROP_X0 = 1'b1,
  parameter int CNT_W   = 32
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rst_n,
  input  logic                     clear,
  input  logic                     debug_wb_have_inst,
  input  logic [31:0]              debug_wb_pc,
  input  logic                     debug_wb_ena,
  input  logic [4:0]               debug_wb_reg,
  input  logic [31:0]              debug_wb_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic                     out_wen,
  output logic [4:0]               out_reg,
  output logic [31:0]              out_value,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         retire_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = 70;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [RW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic          wen_in;
  logic [RW-1:0] rec_in;
  logic [RW-1:0] head;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop     = !empty && out_ready;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
  assign push_ok = debug_wb_have_inst && (!full || pop);
  assign drop    = debug_wb_have_inst && full && !pop;

  assign wen_in  = debug_wb_ena && !(DROP_X0 && (debug_wb_reg == 5'd0));
  assign rec_in  = {debug_wb_pc, wen_in, debug_wb_reg, debug_wb_value};

  assign head      = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign {out_pc, out_wen, out_reg, out_value} = head;
  assign out_valid = !empty;
  assign count     = wr_ptr - rd_ptr;

  // Storage carries no reset; only the pointers decide what is visible.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst_n && push_ok && !clear) begin
      mem[wr_ptr[AW-1:0]] <= rec_in;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      retire_cnt <= '0;
      drop_cnt   <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      retire_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (debug_wb_have_inst) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
      if (drop) begin
        drop_cnt <= sat_inc(drop_cnt);
        overflow <= 1'b1;
      end
    end
  end

endmodule
